dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Shares the single-port data-memory SRAM (14-bit word address, per-byte active-low write enable, 1-cycle read latency) between the CPU MEM stage and a DMA/debug requester.
- CPU has priority. A starvation counter forces a bounded DMA burst slot, during which the CPU is stalled.
- Sits between the MEM stage DM_* outputs and the SRAM macro.

Parameters:
- MAX_WAIT, 8: cycles the DMA may wait while requesting before it forces a slot (1..255).
- DMA_BURST, 4: maximum consecutive DMA beats per forced slot (1..16).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access this cycle (load or store).
- cpu_we  in  4  CPU byte write enables, active-low; 4'b1111 = read.
- cpu_addr  in  14  CPU word address.
- cpu_wdata  in  32  CPU store data, already byte-shifted.
- cpu_rdata  out  32  load data; valid the cycle after a granted CPU read.
- cpu_stall  out  1  CPU access not granted this cycle; MEM/EX must hold.
- dma_req  in  1  DMA access this cycle.
- dma_we  in  4  DMA byte write enables, active-low.
- dma_addr  in  14  DMA word address.
- dma_wdata  in  32  DMA write data.
- dma_gnt  out  1  DMA beat accepted this cycle.
- dma_rvalid  out  1  dma_rdata valid; asserted the cycle after a granted DMA read.
- dma_rdata  out  32  DMA read data.
- DM_write_en  out  4  to SRAM, active-low byte enables.
- DM_addr  out  14  to SRAM.
- DM_data_in  out  32  to SRAM.
- data_from_mem  in  32  SRAM read data (1-cycle latency).

Behaviour:
- FSM states: ARB_CPU (reset state) and ARB_DMA.
- Grant logic is combinational from the current state and counters.
- ARB_CPU grants:
  - DMA is granted when dma_req && (!cpu_req || starve_cnt == MAX_WAIT); otherwise the CPU is granted if cpu_req.
  - A forced grant (cpu_req && starve_cnt == MAX_WAIT) sets cpu_stall=1, loads burst_cnt=1 and moves to ARB_DMA.
  - An opportunistic grant (!cpu_req) stays in ARB_CPU.
- ARB_DMA grants:
  - DMA is granted while dma_req && burst_cnt < DMA_BURST; each beat increments burst_cnt.
  - cpu_stall = cpu_req in every ARB_DMA cycle.
  - Return to ARB_CPU when dma_req drops or the last beat (burst_cnt == DMA_BURST-1 at grant) is taken. burst_cnt clears on exit.
  - A cycle with !dma_req in ARB_DMA grants nothing to the DMA. The CPU is also not granted that cycle, and the state returns to ARB_CPU.
- starve_cnt (8-bit): increments while dma_req && !dma_gnt, saturating at MAX_WAIT. It clears on any dma_gnt or when !dma_req.
- The CPU is never stalled by the DMA unless starve_cnt has reached MAX_WAIT. cpu_stall=0 whenever cpu_req=0.
- SRAM muxing:
  - Granted requester drives DM_write_en/DM_addr/DM_data_in.
  - Nothing granted: DM_write_en=4'b1111, DM_addr=cpu_addr, DM_data_in=cpu_wdata.
  - A non-granted requester's write never reaches the SRAM.
- Read return:
  - A flop rd_owner (0=CPU, 1=DMA) and a flop dma_rd_pend are registered on each granted read (we == 4'b1111).
  - dma_rvalid = dma_rd_pend. dma_rdata = data_from_mem when dma_rd_pend, else 0. cpu_rdata = data_from_mem always.
  - dma_rvalid is never asserted for DMA writes.
- Simultaneous events:
  - CPU and DMA both requesting with starve_cnt < MAX_WAIT: CPU wins.
  - dma_req deasserting in the same cycle starve_cnt reaches MAX_WAIT: no forced grant.
- Reset (rst low, any time, including mid-burst):
  - State returns to ARB_CPU; starve_cnt=0, burst_cnt=0, dma_rd_pend=0, rd_owner=0.
  - Outputs: dma_rvalid=0, dma_gnt=0, cpu_stall=0, DM_write_en=4'b1111.
  - After release, the first edge behaves as from ARB_CPU.

Optional Feature:
- Macro DM_ARB_STALL_CNT_EN.
- Defined: adds output stall_cnt [15:0], counting cycles with cpu_stall=1. The counter saturates at 16'hFFFF and clears on reset.
- Undefined: no port and no counter logic; all other behaviour is identical.

Test Plan:
- CPU only: cpu_req=1, cpu_we=4'b1111, addr 0x0010, SRAM holds 0xDEADBEEF -> cpu_stall=0 and cpu_rdata=0xDEADBEEF next cycle; dma_gnt=0 throughout.
- DMA opportunistic: cpu_req=0, DMA read at 0x0020 -> dma_gnt=1 the same cycle; dma_rvalid=1 with the SRAM word next cycle; starve_cnt stays 0.
- Starvation, MAX_WAIT=8, DMA_BURST=4: cpu_req and dma_req held high -> 8 cycles with CPU granted. Cycle 9 through cycle 12: dma_gnt=1 and cpu_stall=1. Cycle 13: CPU granted, starve_cnt=0.
- Early burst exit: dma_req drops after 2 forced beats -> exactly 2 dma_gnt pulses; the following cycle grants nothing to the DMA and returns to ARB_CPU; CPU granted on the next cycle.
- Write isolation: stalled CPU with cpu_we=4'b1110 during a DMA write (dma_we=4'b0000, 0x12345678 at 0x0005) -> SRAM word 0x0005=0x12345678 and the CPU target is unchanged. Replaying the CPU store after the stall clears writes its byte.
- Async reset mid-burst: rst low between clock edges in ARB_DMA -> dma_gnt, cpu_stall and dma_rvalid drop immediately. After release, CPU is granted on the first cycle.

Source files
------------

// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if
//   Bundles the CPU MEM-stage port, the DMA/debug port and the SRAM-side
//   port of the data-memory arbiter.
//   slave  : arbiter view (takes requests, drives grants/read data/SRAM pins)
//   master : requester/SRAM view (the opposite directions)
interface dm_arbiter_if;
    // CPU side
    logic        cpu_req;
    logic [3:0]  cpu_we;        // active-low byte enables, 4'b1111 = read
    logic [13:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    // DMA/debug side
    logic        dma_req;
    logic [3:0]  dma_we;        // active-low byte enables
    logic [13:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [31:0] dma_rdata;
    // SRAM side
    logic [3:0]  DM_write_en;
    logic [13:0] DM_addr;
    logic [31:0] DM_data_in;
    logic [31:0] data_from_mem;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output DM_write_en, DM_addr, DM_data_in,
        input  data_from_mem
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  DM_write_en, DM_addr, DM_data_in,
        output data_from_mem
    );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter
//   Shares the single-port data-memory SRAM between the CPU MEM stage and a
//   DMA/debug requester. The CPU has priority; a DMA requester that has waited
//   MAX_WAIT cycles gets a forced slot of up to DMA_BURST beats during which
//   the CPU is stalled.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   bus        dm_arbiter_if.slave: CPU request/stall/rdata, DMA
//              request/grant/rvalid/rdata, SRAM write_en/addr/data_in and
//              SRAM read data (1-cycle latency)
//   stall_cnt  [15:0] saturating count of cpu_stall cycles; present only when
//              DM_ARB_STALL_CNT_EN is defined
// Parameters:
//   MAX_WAIT   DMA wait cycles before a forced slot (1..255)
//   DMA_BURST  max consecutive DMA beats per forced slot (1..16)
module dm_arbiter #(
    parameter int MAX_WAIT  = 8,
    parameter int DMA_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    dm_arbiter_if.slave bus
`ifdef DM_ARB_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    typedef enum logic {
        ARB_CPU = 1'b0,
        ARB_DMA = 1'b1
    } arb_state_e;

    localparam logic [7:0] WAIT_MAX   = 8'(MAX_WAIT);
    localparam logic [4:0] BURST_MAX  = 5'(DMA_BURST);
    localparam logic [4:0] BURST_LAST = 5'(DMA_BURST - 1);

    arb_state_e  state_q, state_d;
    logic [7:0]  starve_cnt_q, starve_cnt_d;
    logic [4:0]  burst_cnt_q, burst_cnt_d;
    logic        rd_owner_q, rd_owner_d;
    logic        dma_rd_pend_q, dma_rd_pend_d;

    logic        dma_gnt, cpu_gnt, cpu_stall;
    logic        dma_is_rd, cpu_is_rd;

    assign dma_is_rd = (bus.dma_we == 4'b1111);
    assign cpu_is_rd = (bus.cpu_we == 4'b1111);

    // Grant / next-state logic
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        dma_gnt     = 1'b0;
        cpu_gnt     = 1'b0;
        case (state_q)
            ARB_CPU: begin
                dma_gnt = bus.dma_req && (!bus.cpu_req || starve_cnt_q == WAIT_MAX);
                cpu_gnt = bus.cpu_req && !dma_gnt;
                // A forced beat is the first beat of the slot; with a
                // one-beat slot it is also the last, so stay put.
                if (dma_gnt && bus.cpu_req && DMA_BURST > 1) begin
                    state_d     = ARB_DMA;
                    burst_cnt_d = 5'd1;
                end
            end
            ARB_DMA: begin
                dma_gnt = bus.dma_req && (burst_cnt_q < BURST_MAX);
                if (!dma_gnt || burst_cnt_q == BURST_LAST) begin
                    state_d     = ARB_CPU;
                    burst_cnt_d = 5'd0;
                end else begin
                    burst_cnt_d = burst_cnt_q + 5'd1;
                end
            end
            default: begin
                state_d     = ARB_CPU;
                burst_cnt_d = 5'd0;
            end
        endcase
        // Grants are forced off while reset is held so nothing reaches the
        // SRAM before the arbiter is released.
        if (!rst) begin
            dma_gnt = 1'b0;
            cpu_gnt = 1'b0;
        end
    end

    assign cpu_stall = rst && bus.cpu_req && !cpu_gnt;

    // Starvation counter: counts only while the DMA is actually waiting.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.dma_req || dma_gnt)
            starve_cnt_d = 8'd0;
        else if (starve_cnt_q != WAIT_MAX)
            starve_cnt_d = starve_cnt_q + 8'd1;
    end

    // Read-return bookkeeping, registered on granted reads only.
    always_comb begin
        rd_owner_d    = rd_owner_q;
        dma_rd_pend_d = dma_gnt && dma_is_rd;
        if (dma_gnt && dma_is_rd)
            rd_owner_d = 1'b1;
        else if (cpu_gnt && cpu_is_rd)
            rd_owner_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ARB_CPU;
            starve_cnt_q  <= 8'd0;
            burst_cnt_q   <= 5'd0;
            rd_owner_q    <= 1'b0;
            dma_rd_pend_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            starve_cnt_q  <= starve_cnt_d;
            burst_cnt_q   <= burst_cnt_d;
            rd_owner_q    <= rd_owner_d;
            dma_rd_pend_q <= dma_rd_pend_d;
        end
    end

    // SRAM mux: an ungranted requester never drives write enables.
    always_comb begin
        bus.DM_write_en = 4'b1111;
        bus.DM_addr     = bus.cpu_addr;
        bus.DM_data_in  = bus.cpu_wdata;
        if (dma_gnt) begin
            bus.DM_write_en = bus.dma_we;
            bus.DM_addr     = bus.dma_addr;
            bus.DM_data_in  = bus.dma_wdata;
        end else if (cpu_gnt) begin
            bus.DM_write_en = bus.cpu_we;
        end
    end

    assign bus.cpu_stall  = cpu_stall;
    assign bus.dma_gnt    = dma_gnt;
    assign bus.dma_rvalid = dma_rd_pend_q;
    assign bus.dma_rdata  = (dma_rd_pend_q && rd_owner_q) ? bus.data_from_mem : 32'd0;
    assign bus.cpu_rdata  = bus.data_from_mem;

`ifdef DM_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cpu_stall && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stall_cnt_q <= 16'd0;
        else      stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter
//   Directed scenarios plus a randomized phase. A reference model (wait
//   counter, remaining-beats-in-slot counter, reference memory image) predicts
//   grants, stalls, SRAM pin values and read data every cycle.
module tb_dm_arbiter;
    localparam int MAX_WAIT  = 8;
    localparam int DMA_BURST = 4;

    logic clk;
    logic rst;
    dm_arbiter_if bus();
`ifdef DM_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    dm_arbiter #(.MAX_WAIT(MAX_WAIT), .DMA_BURST(DMA_BURST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef DM_ARB_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model with 1-cycle read latency and a backdoor preload port.
    logic [31:0] sram [0:16383];
    logic [31:0] sram_q;
    logic        bd_en;
    logic [13:0] bd_addr;
    logic [31:0] bd_data;

    always @(posedge clk) begin
        sram_q <= sram[bus.DM_addr];
        for (int b = 0; b < 4; b++)
            if (!bus.DM_write_en[b]) sram[bus.DM_addr][8*b +: 8] <= bus.DM_data_in[8*b +: 8];
        if (bd_en) sram[bd_addr] <= bd_data;
    end
    assign bus.data_from_mem = sram_q;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [31:0] ref_mem [0:16383];
    int          wt;          // cycles the DMA has been waiting
    bit          slot;        // inside a forced DMA slot
    int          left;        // beats still allowed in the slot
    bit          exp_drv, exp_crd;
    logic [31:0] exp_ddata, exp_cdata;
    int          stalls;
    logic        obs_gnt, obs_stall;

    task automatic model_reset();
        wt = 0; slot = 0; left = 0;
        exp_drv = 0; exp_crd = 0; exp_ddata = '0; exp_cdata = '0;
        stalls = 0;
    endtask

    task automatic set_in(input logic creq, input logic [3:0] cwe, input logic [13:0] caddr,
                          input logic [31:0] cwd, input logic dreq, input logic [3:0] dwe,
                          input logic [13:0] daddr, input logic [31:0] dwd);
        bus.cpu_req = creq; bus.cpu_we = cwe; bus.cpu_addr = caddr; bus.cpu_wdata = cwd;
        bus.dma_req = dreq; bus.dma_we = dwe; bus.dma_addr = daddr; bus.dma_wdata = dwd;
    endtask

    task automatic idle_in();
        set_in(1'b0, 4'hF, 14'd0, 32'd0, 1'b0, 4'hF, 14'd0, 32'd0);
    endtask

    // One clock: check comb outputs mid-cycle against the model, then advance.
    task automatic step();
        logic        dg, cg, cs;
        logic [3:0]  ewe;
        logic [13:0] eaddr;
        logic [31:0] edata;
        @(negedge clk);
        if (!slot) dg = bus.dma_req && (!bus.cpu_req || wt >= MAX_WAIT);
        else       dg = bus.dma_req && left > 0;
        cg    = bus.cpu_req && !dg && !slot;
        cs    = bus.cpu_req && !cg;
        ewe   = dg ? bus.dma_we : (cg ? bus.cpu_we : 4'hF);
        eaddr = dg ? bus.dma_addr : bus.cpu_addr;
        edata = dg ? bus.dma_wdata : bus.cpu_wdata;
        obs_gnt   = bus.dma_gnt;
        obs_stall = bus.cpu_stall;
        chk("dma_gnt", bus.dma_gnt, dg);
        chk("cpu_stall", bus.cpu_stall, cs);
        chk("dm_we", bus.DM_write_en, ewe);
        chk("dm_addr", bus.DM_addr, eaddr);
        chk("dm_data", bus.DM_data_in, edata);
        chk("dma_rvalid", bus.dma_rvalid, exp_drv);
        chk("dma_rdata", bus.dma_rdata, exp_drv ? exp_ddata : 32'd0);
        if (exp_crd) chk("cpu_rdata", bus.cpu_rdata, exp_cdata);
`ifdef DM_ARB_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, stalls);
`endif
        exp_drv   = dg && bus.dma_we == 4'hF;
        exp_ddata = ref_mem[bus.dma_addr];
        exp_crd   = cg && bus.cpu_we == 4'hF;
        exp_cdata = ref_mem[bus.cpu_addr];
        for (int b = 0; b < 4; b++)
            if (!ewe[b]) ref_mem[eaddr][8*b +: 8] = edata[8*b +: 8];
        if (!slot) begin
            if (dg && bus.cpu_req && DMA_BURST > 1) begin
                slot = 1; left = DMA_BURST - 1;
            end
        end else begin
            if (dg) left--;
            if (!bus.dma_req || left == 0) slot = 0;
        end
        if (!bus.dma_req || dg) wt = 0;
        else if (wt < MAX_WAIT) wt++;
        if (cs && stalls < 65535) stalls++;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [13:0] a, input logic [31:0] d);
        idle_in();
        bd_en = 1'b1; bd_addr = a; bd_data = d;
        step();
        bd_en = 1'b0;
        ref_mem[a] = d;
    endtask

    logic [12:0] gv, sv;
    int          ng;

    initial begin
        rst = 1'b0;
        bd_en = 1'b0; bd_addr = '0; bd_data = '0;
        model_reset();
        // DMA requesting while in reset must still see no grant.
        set_in(1'b0, 4'hF, 14'd0, 32'd0, 1'b1, 4'h0, 14'd3, 32'h1);
        @(posedge clk); @(posedge clk); #2;
        chk("rst_gnt", bus.dma_gnt, 1'b0);
        chk("rst_stall", bus.cpu_stall, 1'b0);
        chk("rst_rvalid", bus.dma_rvalid, 1'b0);
        chk("rst_we", bus.DM_write_en, 4'hF);
        idle_in();
        rst = 1'b1;
        @(posedge clk); #1;

        for (int a = 0; a < 32; a++) preload(14'(a), $urandom);
        preload(14'h0010, 32'hDEADBEEF);
        preload(14'h0020, 32'hCAFEF00D);
        preload(14'h0005, 32'h0BADF00D);
        preload(14'h0007, 32'hAABBCCDD);

        // CPU only read
        set_in(1'b1, 4'hF, 14'h0010, 32'd0, 1'b0, 4'hF, 14'd0, 32'd0);
        step();
        chk("cpu_only_stall", obs_stall, 1'b0);
        chk("cpu_only_gnt", obs_gnt, 1'b0);
        chk("cpu_only_rdata", bus.cpu_rdata, 32'hDEADBEEF);
        idle_in(); step();

        // DMA opportunistic read
        set_in(1'b0, 4'hF, 14'd0, 32'd0, 1'b1, 4'hF, 14'h0020, 32'd0);
        step();
        chk("opp_gnt", obs_gnt, 1'b1);
        chk("opp_rvalid", bus.dma_rvalid, 1'b1);
        chk("opp_rdata", bus.dma_rdata, 32'hCAFEF00D);
        idle_in(); step();

        // Starvation: cycles 9..12 are DMA beats with the CPU stalled
        set_in(1'b1, 4'hF, 14'd1, 32'd0, 1'b1, 4'hF, 14'd2, 32'd0);
        for (int i = 0; i < 13; i++) begin
            step();
            gv[i] = obs_gnt; sv[i] = obs_stall;
        end
        chk("starve_gnt_pat", gv, 13'h0F00);
        chk("starve_stall_pat", sv, 13'h0F00);
        idle_in(); step();

        // Early burst exit after 2 forced beats
        set_in(1'b1, 4'hF, 14'd1, 32'd0, 1'b1, 4'hF, 14'd2, 32'd0);
        ng = 0;
        for (int i = 0; i < 10; i++) begin step(); ng += int'(obs_gnt); end
        bus.dma_req = 1'b0;
        step();
        chk("early_nogrant", obs_gnt, 1'b0);
        chk("early_stall", obs_stall, 1'b1);
        step();
        chk("early_cpu_gnt", obs_stall, 1'b0);
        chk("early_beats", ng, 2);
        idle_in(); step();

        // Write isolation: stalled CPU store must not hit the SRAM
        set_in(1'b1, 4'hF, 14'd1, 32'd0, 1'b1, 4'hF, 14'd5, 32'd0);
        for (int i = 0; i < 8; i++) step();
        set_in(1'b1, 4'b1110, 14'd7, 32'h55555599, 1'b1, 4'b0000, 14'd5, 32'h12345678);
        step();
        chk("wi_forced", obs_gnt, 1'b1);
        bus.dma_req = 1'b0;
        step();
        chk("wi_dma_word", sram[5], 32'h12345678);
        chk("wi_cpu_untouched", sram[7], 32'hAABBCCDD);
        step();
        chk("wi_replay_stall", obs_stall, 1'b0);
        chk("wi_replay_word", sram[7], 32'hAABBCC99);
        idle_in(); step();

        // Async reset in the middle of a forced slot
        set_in(1'b1, 4'hF, 14'd3, 32'd0, 1'b1, 4'hF, 14'd4, 32'd0);
        for (int i = 0; i < 9; i++) step();
        #1;
        chk("pre_rst_rvalid", bus.dma_rvalid, 1'b1);
        chk("pre_rst_gnt", bus.dma_gnt, 1'b1);
        rst = 1'b0;
        #1;
        chk("mid_rst_gnt", bus.dma_gnt, 1'b0);
        chk("mid_rst_stall", bus.cpu_stall, 1'b0);
        chk("mid_rst_rvalid", bus.dma_rvalid, 1'b0);
        chk("mid_rst_we", bus.DM_write_en, 4'hF);
        @(posedge clk); #2;
        rst = 1'b1;
        model_reset();
        step();
        chk("post_rst_cpu_gnt", obs_stall, 1'b0);
        idle_in(); step();

        // Randomized traffic over a small address window
        for (int i = 0; i < 800; i++) begin
            logic [3:0] cw, dw;
            case ($urandom_range(0, 3))
                0: cw = 4'hF; 1: cw = 4'h0; 2: cw = 4'($urandom); default: cw = 4'hF;
            endcase
            case ($urandom_range(0, 3))
                0: dw = 4'hF; 1: dw = 4'h0; 2: dw = 4'($urandom); default: dw = 4'hF;
            endcase
            set_in($urandom_range(0, 9) < 7, cw, 14'($urandom_range(0, 31)), $urandom,
                   $urandom_range(0, 9) < 6, dw, 14'($urandom_range(0, 31)), $urandom);
            step();
        end
        idle_in(); step(); step();

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end
endmodule
